alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Multi-cycle issue/writeback sequencer that sits on the control side of the datapath ALU. It accepts one instruction at a time through a valid/ready handshake and reads the two source registers. It then drives the ALU opcode and operands, captures the ALU outputs (result, high word, Pos/Neg) and writes results back to the register file. It holds the architectural Pos/Neg flags used by branch logic.

Parameters:
DATA_W, 16, operand/result width (ALU is fixed 16-bit; other values unsupported)
REG_AW, 4, register-file address width
HI_REG, 0, register index that receives the high word (R0) of MUL/DIV

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
issue_valid  in  1  instruction offered
issue_ready  out  1  controller can accept (IDLE and rst_n high)
issue_op  in  3  ALU op: 000 ADD, 001 SUB, 010 MUL, 100 DIV, 101 AND, 110 OR, 111 IMMADD; 011 illegal
issue_rd  in  REG_AW  destination register
issue_rs1  in  REG_AW  source 1
issue_rs2  in  REG_AW  source 2
issue_immd  in  DATA_W  immediate
rf_raddr1  out  REG_AW  register read address 1 (combinational read)
rf_raddr2  out  REG_AW  register read address 2
rf_rdata1  in  DATA_W  read data 1
rf_rdata2  in  DATA_W  read data 2
rf_we  out  1  register write enable
rf_waddr  out  REG_AW  write address
rf_wdata  out  DATA_W  write data
alu_ctrl  out  3  opcode to ALU
alu_op1  out  DATA_W  ALU operand 1 (registered)
alu_op2  out  DATA_W  ALU operand 2 (registered)
alu_immd  out  DATA_W  ALU immediate (registered)
alu_result  in  DATA_W  ALU Result
alu_hi  in  DATA_W  ALU R0 (high word)
alu_pos  in  1  ALU Pos
alu_neg  in  1  ALU Neg
flag_pos  out  1  architectural positive flag
flag_neg  out  1  architectural negative flag
done  out  1  one-cycle completion pulse
err_illegal  out  1  with done: illegal opcode, no writeback
err_div0  out  1  with done: divide by zero, no writeback

Behaviour:
- States: IDLE, READ, EXEC, WB_LO, WB_HI, ERR.
- Reset (rst_n low at the edge): state=IDLE. All registered outputs are 0: alu_*, rf_*, flags, done, err_*. issue_ready is forced to 0 while rst_n is low.
- Reset asserted in any state aborts the operation: no register write, no done pulse.
- IDLE: issue_ready=1. On issue_valid&&issue_ready, capture op/rd/rs1/rs2/immd.
  - Op 011 goes to ERR.
  - Any other op goes to READ.
- READ: rf_raddr1=rs1, rf_raddr2=rs2. At the edge, latch alu_op1/alu_op2/alu_immd and alu_ctrl=op, then go to EXEC.
- EXEC: the ALU evaluates combinationally; capture alu_result/alu_hi/alu_pos/alu_neg at the edge.
  - If op=DIV and alu_op2==0, go to ERR with err_div0. The ALU output is ignored.
  - Otherwise go to WB_LO.
- WB_LO: rf_we=1, rf_waddr=rd, rf_wdata=captured result.
  - MUL/DIV go to WB_HI.
  - All other ops assert done and return to IDLE.
- WB_HI: rf_we=1, rf_waddr=HI_REG, rf_wdata=captured hi. Assert done and go to IDLE.
  - If rd==HI_REG, the hi word is the final value.
- ERR: done=1 with the matching err_* bit, rf_we=0. Return to IDLE.
- Latency, counted from handshake edge to done cycle:
  - ADD/SUB/AND/OR/IMMADD: 3 cycles.
  - MUL/DIV: 4 cycles.
  - Illegal opcode: 1 cycle.
  - Divide by zero: 3 cycles.
- Throughput: next accept in the cycle after done; no overlap.
- Flags: updated only on a completed SUB, at the EXEC→WB_LO edge.
  - result>0 gives pos=1, neg=0; result<0 gives pos=0, neg=1; result==0 clears both. The controller computes zero itself and does not trust the ALU's stale Pos/Neg.
  - All other ops hold the flags.
- Arithmetic is two's complement, 16-bit wrap. DIV -32768/-1 writes whatever the ALU produces (no error).
- rf_we is 0 outside WB_LO/WB_HI. done, err_illegal and err_div0 are single-cycle pulses.

Optional Feature:
ALU_ISSUE_ZERO_FLAG_EN:
- When defined, adds output flag_zero (1 bit, reset 0), set when a completed SUB produces 0 and cleared on any other SUB.
- When undefined, the port and register are absent and the flag behaviour is as above.

Decomposition:
- Package alu_pkg: op encodings (OP_ADD..OP_IMMADD, OP_ILLEGAL=3'b011), state enum, DATA_W constant.
- Sub-module alu_op_decode (combinational): op → legal, is_muldiv, updates_flags.

Test Plan:
- ADD: R1=5, R2=7, rd=3 → rf write R3=12 in WB_LO; done 3 cycles after handshake; flags unchanged.
- MUL: R1=300, R2=300 (90000=0x15F90), rd=4 → R4=0x5F90, then R0=0x0001; done at cycle 4.
- SUB chain: 3-9 → flag_neg=1; 9-3 → flag_pos=1; 4-4 → both 0 (flag_zero=1 with macro).
- DIV by zero: R2=0 → err_div0 and done together, no rf_we; illegal op 011 → err_illegal+done next cycle, no reads.
- rst_n low during WB_LO of a MUL → no WB_HI write, outputs 0, issue_ready=1 the cycle after release.
- Back-to-back: issue_valid held high with two ops → the second is accepted only in the cycle after the first done; rd==HI_REG MUL leaves the hi word in R0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared constants for the ALU issue controller.
//   DATA_W       - ALU datapath width (the ALU is fixed at 16 bits)
//   OP_*         - 3-bit ALU opcode encodings, OP_ILLEGAL is the unused code
//   state_e      - issue/writeback sequencer states
package alu_pkg;

  localparam int DATA_W = 16;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_SUB     = 3'b001;
  localparam logic [2:0] OP_MUL     = 3'b010;
  localparam logic [2:0] OP_ILLEGAL = 3'b011;
  localparam logic [2:0] OP_DIV     = 3'b100;
  localparam logic [2:0] OP_AND     = 3'b101;
  localparam logic [2:0] OP_OR      = 3'b110;
  localparam logic [2:0] OP_IMMADD  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB_LO = 3'd3,
    ST_WB_HI = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational classification of an ALU opcode.
//   op            in  3  ALU opcode
//   legal         out 1  opcode is implemented (everything except 3'b011)
//   is_muldiv     out 1  opcode produces a high word (MUL, DIV)
//   updates_flags out 1  opcode updates the architectural Pos/Neg flags (SUB)
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [2:0] op,
  output logic       legal,
  output logic       is_muldiv,
  output logic       updates_flags
);

  assign legal         = (op != OP_ILLEGAL);
  assign is_muldiv     = (op == OP_MUL) || (op == OP_DIV);
  assign updates_flags = (op == OP_SUB);

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: multi-cycle issue/writeback sequencer for the datapath ALU.
// Accepts one instruction at a time, reads its two sources, drives the ALU,
// captures its outputs and writes the result (and the high word of MUL/DIV
// into HI_REG) back to the register file. Holds the architectural Pos/Neg flags.
//
// Handshake: an instruction transfers on a rising edge where issue_valid and
// issue_ready are both 1. issue_ready is 1 only in IDLE with rst_n high, so
// the next transfer can happen no earlier than the cycle after done.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   issue_valid/ready          instruction handshake
//   issue_op/rd/rs1/rs2/immd   instruction fields
//   rf_raddr1/2, rf_rdata1/2   register-file read (combinational data return)
//   rf_we/waddr/wdata          register-file write
//   alu_ctrl/op1/op2/immd      registered ALU inputs
//   alu_result/hi/pos/neg      ALU outputs
//   flag_pos/flag_neg          architectural flags (updated by SUB only)
//   flag_zero                  only with ALU_ISSUE_ZERO_FLAG_EN defined
//   done, err_illegal, err_div0  single-cycle completion/error pulses
//
// Optional feature: define ALU_ISSUE_ZERO_FLAG_EN to add flag_zero.
module alu_issue_ctrl #(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int REG_AW = 4,
  parameter int HI_REG = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [2:0]        issue_op,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic [DATA_W-1:0] issue_immd,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [2:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  output logic [DATA_W-1:0] alu_immd,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] alu_hi,
  input  logic              alu_pos,
  input  logic              alu_neg,
  output logic              flag_pos,
  output logic              flag_neg,
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  output logic              flag_zero,
`endif
  output logic              done,
  output logic              err_illegal,
  output logic              err_div0
);
  import alu_pkg::*;

  localparam logic [REG_AW-1:0] HI_ADDR = REG_AW'(HI_REG);

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic              muldiv_q, muldiv_d;
  logic              upd_q, upd_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] immd_q, immd_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [REG_AW-1:0] rf_raddr1_q, rf_raddr1_d, rf_raddr2_q, rf_raddr2_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic [DATA_W-1:0] alu_op1_q, alu_op1_d, alu_op2_q, alu_op2_d;
  logic [DATA_W-1:0] alu_immd_q, alu_immd_d;
  logic              flag_pos_q, flag_pos_d, flag_neg_q, flag_neg_d;
  logic              flag_zero_q, flag_zero_d;
  logic              done_q, done_d;
  logic              err_illegal_q, err_illegal_d;
  logic              err_div0_q, err_div0_d;

  logic in_legal, in_muldiv, in_upd;
  logic res_zero;

  // The ALU's Pos/Neg may be stale when the result is zero, so the flags are
  // derived from the captured result instead; the ALU flag inputs are sunk here.
  logic unused_alu_flags;
  assign unused_alu_flags = alu_pos | alu_neg;

  alu_op_decode u_decode (
    .op            (issue_op),
    .legal         (in_legal),
    .is_muldiv     (in_muldiv),
    .updates_flags (in_upd)
  );

  assign res_zero = (alu_result == '0);

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    muldiv_d      = muldiv_q;
    upd_d         = upd_q;
    rd_d          = rd_q;
    immd_d        = immd_q;
    hi_d          = hi_q;
    rf_raddr1_d   = rf_raddr1_q;
    rf_raddr2_d   = rf_raddr2_q;
    rf_we_d       = 1'b0;
    rf_waddr_d    = rf_waddr_q;
    rf_wdata_d    = rf_wdata_q;
    alu_ctrl_d    = alu_ctrl_q;
    alu_op1_d     = alu_op1_q;
    alu_op2_d     = alu_op2_q;
    alu_immd_d    = alu_immd_q;
    flag_pos_d    = flag_pos_q;
    flag_neg_d    = flag_neg_q;
    flag_zero_d   = flag_zero_q;
    done_d        = 1'b0;
    err_illegal_d = 1'b0;
    err_div0_d    = 1'b0;

    // Registered outputs are computed one state ahead so they are valid
    // during the cycle the FSM sits in the named state.
    case (state_q)
      ST_IDLE: begin
        if (issue_valid) begin
          op_d     = issue_op;
          muldiv_d = in_muldiv;
          upd_d    = in_upd;
          rd_d     = issue_rd;
          immd_d   = issue_immd;
          if (!in_legal) begin
            state_d       = ST_ERR;
            done_d        = 1'b1;
            err_illegal_d = 1'b1;
          end else begin
            state_d     = ST_READ;
            rf_raddr1_d = issue_rs1;
            rf_raddr2_d = issue_rs2;
          end
        end
      end
      ST_READ: begin
        alu_op1_d   = rf_rdata1;
        alu_op2_d   = rf_rdata2;
        alu_immd_d  = immd_q;
        alu_ctrl_d  = op_q;
        rf_raddr1_d = '0;
        rf_raddr2_d = '0;
        state_d     = ST_EXEC;
      end
      ST_EXEC: begin
        hi_d = alu_hi;
        if ((op_q == OP_DIV) && (alu_op2_q == '0)) begin
          state_d    = ST_ERR;
          done_d     = 1'b1;
          err_div0_d = 1'b1;
        end else begin
          state_d    = ST_WB_LO;
          rf_we_d    = 1'b1;
          rf_waddr_d = rd_q;
          rf_wdata_d = alu_result;
          done_d     = !muldiv_q;
          if (upd_q) begin
            flag_pos_d  = !alu_result[DATA_W-1] && !res_zero;
            flag_neg_d  = alu_result[DATA_W-1];
            flag_zero_d = res_zero;
          end
        end
      end
      ST_WB_LO: begin
        if (muldiv_q) begin
          state_d    = ST_WB_HI;
          rf_we_d    = 1'b1;
          rf_waddr_d = HI_ADDR;
          rf_wdata_d = hi_q;
          done_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB_HI: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      op_q          <= '0;
      muldiv_q      <= 1'b0;
      upd_q         <= 1'b0;
      rd_q          <= '0;
      immd_q        <= '0;
      hi_q          <= '0;
      rf_raddr1_q   <= '0;
      rf_raddr2_q   <= '0;
      rf_we_q       <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      alu_ctrl_q    <= '0;
      alu_op1_q     <= '0;
      alu_op2_q     <= '0;
      alu_immd_q    <= '0;
      flag_pos_q    <= 1'b0;
      flag_neg_q    <= 1'b0;
      flag_zero_q   <= 1'b0;
      done_q        <= 1'b0;
      err_illegal_q <= 1'b0;
      err_div0_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      muldiv_q      <= muldiv_d;
      upd_q         <= upd_d;
      rd_q          <= rd_d;
      immd_q        <= immd_d;
      hi_q          <= hi_d;
      rf_raddr1_q   <= rf_raddr1_d;
      rf_raddr2_q   <= rf_raddr2_d;
      rf_we_q       <= rf_we_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      alu_ctrl_q    <= alu_ctrl_d;
      alu_op1_q     <= alu_op1_d;
      alu_op2_q     <= alu_op2_d;
      alu_immd_q    <= alu_immd_d;
      flag_pos_q    <= flag_pos_d;
      flag_neg_q    <= flag_neg_d;
      flag_zero_q   <= flag_zero_d;
      done_q        <= done_d;
      err_illegal_q <= err_illegal_d;
      err_div0_q    <= err_div0_d;
    end
  end

  assign issue_ready = rst_n && (state_q == ST_IDLE);
  assign rf_raddr1   = rf_raddr1_q;
  assign rf_raddr2   = rf_raddr2_q;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_immd    = alu_immd_q;
  assign flag_pos    = flag_pos_q;
  assign flag_neg    = flag_neg_q;
  assign done        = done_q;
  assign err_illegal = err_illegal_q;
  assign err_div0    = err_div0_q;

`ifdef ALU_ISSUE_ZERO_FLAG_EN
  assign flag_zero = flag_zero_q;
`else
  logic unused_flag_zero;
  assign unused_flag_zero = flag_zero_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int HI = 0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          issue_valid, issue_ready;
  logic [2:0]    issue_op;
  logic [AW-1:0] issue_rd, issue_rs1, issue_rs2;
  logic [DW-1:0] issue_immd;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic [DW-1:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic          rf_we;
  logic [2:0]    alu_ctrl;
  logic [DW-1:0] alu_op1, alu_op2, alu_immd, alu_result, alu_hi;
  logic          alu_pos, alu_neg;
  logic          flag_pos, flag_neg, done, err_illegal, err_div0;
`ifdef ALU_ISSUE_ZERO_FLAG_EN
  logic          flag_zero;
`endif

  alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW), .HI_REG(HI)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_immd(issue_immd),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_ctrl(alu_ctrl), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_immd(alu_immd),
    .alu_result(alu_result), .alu_hi(alu_hi), .alu_pos(alu_pos), .alu_neg(alu_neg),
    .flag_pos(flag_pos), .flag_neg(flag_neg),
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    .flag_zero(flag_zero),
`endif
    .done(done), .err_illegal(err_illegal), .err_div0(err_div0)
  );

  // ---------------- register file and ALU environment ----------------
  logic [DW-1:0] tb_rf [16];
  logic [DW-1:0] model_rf [16];
  assign rf_rdata1 = tb_rf[rf_raddr1];
  assign rf_rdata2 = tb_rf[rf_raddr2];
  always @(posedge clk) if (rf_we) tb_rf[rf_waddr] <= rf_wdata;

  logic signed [31:0] sa, sb, pr, qt, rm;
  always_comb begin
    sa = {{16{alu_op1[15]}}, alu_op1};
    sb = {{16{alu_op2[15]}}, alu_op2};
    pr = sa * sb;
    qt = 32'sd0;
    rm = 32'sd0;
    if (sb != 0) begin
      qt = sa / sb;
      rm = sa % sb;
    end
    alu_result = '0;
    alu_hi     = '0;
    case (alu_ctrl)
      OP_ADD:    alu_result = alu_op1 + alu_op2;
      OP_SUB:    alu_result = alu_op1 - alu_op2;
      OP_MUL:    begin alu_result = pr[15:0]; alu_hi = pr[31:16]; end
      OP_DIV:    begin
        if (sb == 0) begin alu_result = 16'hFFFF; alu_hi = alu_op1; end
        else begin alu_result = qt[15:0]; alu_hi = rm[15:0]; end
      end
      OP_AND:    alu_result = alu_op1 & alu_op2;
      OP_OR:     alu_result = alu_op1 | alu_op2;
      OP_IMMADD: alu_result = alu_op1 + alu_immd;
      default:   alu_result = 16'hDEAD;
    endcase
    // Pos reports 1 on zero, mimicking a stale ALU flag the controller must ignore
    alu_pos = !alu_result[15];
    alu_neg = alu_result[15];
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs_q[$];
  logic m_pos = 0, m_neg = 0, m_zero = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_reg(input int idx, input logic [DW-1:0] v);
    tb_rf[idx] <= v;
    model_rf[idx] = v;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_pos"}, flag_pos, m_pos);
    check({tag, "_neg"}, flag_neg, m_neg);
`ifdef ALU_ISSUE_ZERO_FLAG_EN
    check({tag, "_zero"}, flag_zero, m_zero);
`endif
  endtask

  // Reference model: architectural effect of one instruction on model_rf/flags.
  task automatic model_op(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                          input logic [DW-1:0] imm, output int lat, output bit e_ill,
                          output bit e_d0);
    int a, b, r, hi_w;
    longint p;
    bit two;
    a = {{16{model_rf[rs1][15]}}, model_rf[rs1]};
    b = {{16{model_rf[rs2][15]}}, model_rf[rs2]};
    e_ill = 0; e_d0 = 0; two = 0; r = 0; hi_w = 0;
    exp_q.delete();
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: begin p = longint'(a) * longint'(b); r = int'(p); hi_w = int'(p >>> 16); two = 1; end
      3'd4: begin
        if (b == 0) e_d0 = 1;
        else begin r = a / b; hi_w = a % b; two = 1; end
      end
      3'd5: r = a & b;
      3'd6: r = a | b;
      3'd7: r = a + int'($signed({1'b0, imm}) - ((imm[15]) ? 65536 : 0));
      default: e_ill = 1;
    endcase
    if (e_ill) lat = 1;
    else if (e_d0) lat = 3;
    else begin
      lat = two ? 4 : 3;
      exp_q.push_back({4'(rd), 16'(r)});
      model_rf[rd] = 16'(r);
      if (two) begin
        exp_q.push_back({4'(HI), 16'(hi_w)});
        model_rf[HI] = 16'(hi_w);
      end
      if (op == 3'd1) begin
        m_zero = (16'(r) == 16'd0);
        m_neg  = r[15];
        m_pos  = !m_zero && !r[15];
      end
    end
  endtask

  // ---------------- driver ----------------
  // Entered and left on a falling edge; returns in the done cycle.
  task automatic do_op(input logic [2:0] op, input int rd, input int rs1, input int rs2,
                       input logic [DW-1:0] imm, input bit keep, input int exp_wait);
    int lat, waits, n;
    bit e_ill, e_d0;
    model_op(op, rd, rs1, rs2, imm, lat, e_ill, e_d0);
    issue_valid = 1; issue_op = op; issue_rd = 4'(rd);
    issue_rs1 = 4'(rs1); issue_rs2 = 4'(rs2); issue_immd = imm;
    waits = 0;
    while (!issue_ready && waits < 20) begin @(negedge clk); waits++; end
    if (!issue_ready) begin
      check("accept_timeout", 0, 1);
      issue_valid = 0;
      return;
    end
    if (exp_wait >= 0) check("accept_wait", waits, exp_wait);
    @(negedge clk);
    if (!keep) issue_valid = 0;
    n = 1;
    obs_q.delete();
    while (!done && n < 10) begin
      if (rf_we) obs_q.push_back({rf_waddr, rf_wdata});
      @(negedge clk);
      n++;
    end
    if (rf_we) obs_q.push_back({rf_waddr, rf_wdata});
    check("done_seen", done, 1);
    check("latency", n, lat);
    check("err_illegal", err_illegal, e_ill);
    check("err_div0", err_div0, e_d0);
    check("ready_in_done", issue_ready, 0);
    check("wr_count", obs_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < obs_q.size()) check("wr_data", obs_q[i], exp_q[i]);
    check_flags("flags");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int gap, op, rd, rs1, rs2;
    issue_valid = 0; issue_op = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0; issue_immd = 0;
    for (int i = 0; i < 16; i++) begin
      tb_rf[i] = 16'($urandom);
      model_rf[i] = tb_rf[i];
    end
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", issue_ready, 0);
    check("rst_we", rf_we, 0);
    check("rst_done", done, 0);
    check("rst_ctrl", alu_ctrl, 0);
    check("rst_op1", alu_op1, 0);
    check_flags("rst_flags");
    rst_n = 1;
    @(negedge clk);
    check("ready_after_rst", issue_ready, 1);

    // ADD: 5 + 7 -> R3
    set_reg(1, 16'd5); set_reg(2, 16'd7);
    @(negedge clk);
    do_op(OP_ADD, 3, 1, 2, 0, 0, 0);
    // MUL: 300*300 = 0x15F90
    @(negedge clk);
    set_reg(1, 16'd300); set_reg(2, 16'd300);
    @(negedge clk);
    do_op(OP_MUL, 4, 1, 2, 0, 0, 0);
    // SUB chain
    @(negedge clk);
    set_reg(5, 16'd3); set_reg(6, 16'd9); set_reg(8, 16'd4);
    @(negedge clk);
    do_op(OP_SUB, 7, 5, 6, 0, 0, 0);
    check("sub_neg", flag_neg, 1);
    @(negedge clk);
    do_op(OP_SUB, 7, 6, 5, 0, 0, 0);
    check("sub_pos", flag_pos, 1);
    @(negedge clk);
    do_op(OP_SUB, 7, 8, 8, 0, 0, 0);
    check("sub_zero_pos", flag_pos, 0);
    check("sub_zero_neg", flag_neg, 0);
    // DIV by zero, illegal, -32768 / -1
    @(negedge clk);
    set_reg(9, 16'd0); set_reg(11, 16'h8000); set_reg(12, 16'hFFFF);
    @(negedge clk);
    do_op(OP_DIV, 10, 1, 9, 0, 0, 0);
    @(negedge clk);
    do_op(OP_ILLEGAL, 10, 1, 2, 0, 0, 0);
    @(negedge clk);
    do_op(OP_DIV, 13, 11, 12, 0, 0, 0);

    // Reset during WB_LO of a MUL: low word commits, high word never does
    @(negedge clk);
    set_reg(1, 16'd300); set_reg(2, 16'd300); set_reg(0, 16'h1234);
    @(negedge clk);
    issue_valid = 1; issue_op = OP_MUL; issue_rd = 4'd5; issue_rs1 = 4'd1; issue_rs2 = 4'd2;
    @(negedge clk);
    issue_valid = 0;
    for (int i = 0; i < 10 && !rf_we; i++) @(negedge clk);
    check("rst_mid_we_seen", rf_we, 1);
    model_rf[5] = 16'h5F90;
    rst_n = 0;
    @(negedge clk);
    check("rst_mid_we", rf_we, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_ready", issue_ready, 0);
    check("rst_mid_wdata", rf_wdata, 0);
    m_pos = 0; m_neg = 0; m_zero = 0;
    check_flags("rst_mid_flags");
    rst_n = 1;
    @(negedge clk);
    check("rst_mid_ready_after", issue_ready, 1);
    for (int i = 0; i < 3; i++) begin
      check("rst_mid_no_hi", rf_we, 0);
      @(negedge clk);
    end

    // Back-to-back with issue_valid held; MUL into HI_REG keeps the hi word
    do_op(OP_MUL, HI, 1, 2, 0, 1, 0);
    do_op(OP_ADD, 14, 5, 6, 0, 0, 1);

    // Randomized traffic
    for (int k = 0; k < 60; k++) begin
      gap = $urandom_range(0, 2);
      op  = $urandom_range(0, 7);
      rd  = $urandom_range(0, 15);
      rs1 = $urandom_range(0, 15);
      rs2 = $urandom_range(0, 15);
      if (gap > 0) begin
        repeat (gap) @(negedge clk);
        if (op == 4 && $urandom_range(0, 3) == 0) set_reg(rs2, 16'd0);
        if ($urandom_range(0, 3) == 0) set_reg(rs1, 16'($urandom));
      end
      do_op(3'(op), rd, rs1, rs2, 16'($urandom), 0, (gap > 0) ? 0 : 1);
    end

    repeat (2) @(negedge clk);
    for (int i = 0; i < 16; i++) check("rf_final", tb_rf[i], model_rf[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
